led_activity_stretcher: RTL and testbench

Parametrised multi-channel activity indicator. It converts single-cycle or level strobes into human-visible LED indications, such as run_log/read_log from the register file, MEMLog status and DSP events. Each channel has a runtime-selectable mode: one-shot hold, retriggerable hold, blinking hold, or latch-until-clear. All timing derives from one shared tick prescaler. The block sits between the control/status logic and the board LED/RGB pins and replaces hand-written per-flag counters.

---
 rtl/led_stretch_pkg.sv | 22 ++
 rtl/led_stretch_ch.sv | 133 +++++++++++++
 rtl/led_activity_stretcher.sv | 91 +++++++++
 tb/tb_led_activity_stretcher.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_stretch_pkg.sv
// Shared definitions for the LED activity stretcher.
// Contents: per-channel mode codes, channel FSM state encoding and a
// counter-width helper that never returns a zero width.
package led_stretch_pkg;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RETRIG  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_LATCH   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_LATCH = 2'd2
    } ch_state_e;

    // Width of a counter holding 0..n-1; at least one bit so n=1 stays legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One activity-stretcher channel: IDLE/HOLD/LATCH FSM with hold and blink
// counters and a sticky overrun flag.
// Ports:
//   clk        rising-edge clock
//   i_rst      synchronous active-high reset
//   i_tick     shared prescaler tick (one cycle wide)
//   i_event    trigger strobe/level
//   i_mode     channel mode (ONESHOT/RETRIG/BLINK/LATCH)
//   i_clear    returns the channel to IDLE and clears overrun
//   i_led_en   brightness gate applied to the LED output
//   o_active   channel not IDLE (registered)
//   o_led      LED drive (registered, same cycle as o_active)
//   o_overrun  sticky: event seen while a ONESHOT hold was running
module led_stretch_ch
    import led_stretch_pkg::*;
#(
    parameter int unsigned HOLD_TICKS  = 1000,
    parameter int unsigned BLINK_TICKS = 125
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_event,
    input  logic       i_clear,
    input  logic [1:0] i_mode,
    input  logic       i_led_en,
    output logic       o_active,
    output logic       o_led,
    output logic       o_overrun
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int unsigned BLINK_W = cnt_width(BLINK_TICKS);

    ch_state_e          state_q,     state_nxt;
    logic [HOLD_W-1:0]  hold_q,      hold_nxt;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_nxt;
    logic               phase_q,     phase_nxt;
    logic               overrun_nxt;
    logic               active_nxt;
    logic               led_nxt;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            o_overrun   <= 1'b0;
            o_active    <= 1'b0;
            o_led       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            hold_q      <= hold_nxt;
            blink_cnt_q <= blink_cnt_nxt;
            phase_q     <= phase_nxt;
            o_overrun   <= overrun_nxt;
            o_active    <= active_nxt;
            o_led       <= led_nxt;
        end
    end

    // Next-state logic: clear > event > tick.
    always_comb begin
        state_nxt     = state_q;
        hold_nxt      = hold_q;
        blink_cnt_nxt = blink_cnt_q;
        phase_nxt     = phase_q;
        overrun_nxt   = o_overrun;

        if (i_clear) begin
            state_nxt     = ST_IDLE;
            hold_nxt      = '0;
            blink_cnt_nxt = '0;
            phase_nxt     = 1'b0;
            overrun_nxt   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_event) begin
                        // Blink restarts lit on any new activation.
                        blink_cnt_nxt = '0;
                        phase_nxt     = 1'b1;
                        if (i_mode == MODE_LATCH) begin
                            state_nxt = ST_LATCH;
                        end else begin
                            state_nxt = ST_HOLD;
                            hold_nxt  = HOLD_W'(HOLD_TICKS);
                        end
                    end
                end
                ST_HOLD: begin
                    // Blink timebase advances on ticks while in BLINK mode.
                    if (i_tick && (i_mode == MODE_BLINK)) begin
                        if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                            blink_cnt_nxt = '0;
                            phase_nxt     = ~phase_q;
                        end else begin
                            blink_cnt_nxt = blink_cnt_q + BLINK_W'(1);
                        end
                    end
                    // A retriggering event beats a coincident tick.
                    if (i_event && (i_mode != MODE_ONESHOT)) begin
                        hold_nxt = HOLD_W'(HOLD_TICKS);
                    end else begin
                        if (i_event) begin
                            overrun_nxt = 1'b1;
                        end
                        if (i_tick) begin
                            if (hold_q == HOLD_W'(1)) begin
                                state_nxt = ST_IDLE;
                                hold_nxt  = '0;
                            end else begin
                                hold_nxt = hold_q - HOLD_W'(1);
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    state_nxt = ST_LATCH;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        active_nxt = (state_nxt != ST_IDLE);
        led_nxt    = active_nxt && ((i_mode != MODE_BLINK) || phase_nxt) && i_led_en;
    end

endmodule

// File: rtl/led_activity_stretcher.sv
// Multi-channel LED activity stretcher: turns event strobes into visible
// LED indications with per-channel ONESHOT/RETRIG/BLINK/LATCH modes, all
// timed by one shared tick prescaler.
// Optional feature macro: LED_PWM_EN adds i_duty and a shared PWM counter
// that dims every LED output.
// Ports:
//   clk        rising-edge clock
//   i_rst      synchronous active-high reset
//   i_event    per-channel trigger
//   i_mode     per-channel mode, bits [2k+1:2k]
//   i_clear    per-channel clear strobe
//   i_duty     global brightness (LED_PWM_EN only)
//   o_active   per-channel not-IDLE
//   o_led      per-channel LED drive
//   o_overrun  per-channel sticky ONESHOT overrun flag
module led_activity_stretcher
    import led_stretch_pkg::*;
#(
    parameter int unsigned NB_CH       = 4,
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned HOLD_TICKS  = 1000,
    parameter int unsigned BLINK_TICKS = 125,
    parameter int unsigned NB_PWM      = 4
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [NB_CH-1:0]     i_event,
    input  logic [2*NB_CH-1:0]   i_mode,
    input  logic [NB_CH-1:0]     i_clear,
`ifdef LED_PWM_EN
    input  logic [NB_PWM-1:0]    i_duty,
`endif
    output logic [NB_CH-1:0]     o_active,
    output logic [NB_CH-1:0]     o_led,
    output logic [NB_CH-1:0]     o_overrun
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] presc_q;
    logic             tick;
    logic             led_en;

    assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

    // Free-running shared tick prescaler.
    always_ff @(posedge clk) begin
        if (i_rst || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

`ifdef LED_PWM_EN
    logic [NB_PWM-1:0] pwm_cnt_q;

    // Shared PWM counter; LEDs are lit while it is below the duty value.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + NB_PWM'(1);
        end
    end

    assign led_en = (pwm_cnt_q < i_duty);
`else
    // No dimming: LEDs follow their base value.
    assign led_en = (NB_PWM != 0);
`endif

    for (genvar k = 0; k < NB_CH; k++) begin : g_ch
        led_stretch_ch #(
            .HOLD_TICKS  (HOLD_TICKS),
            .BLINK_TICKS (BLINK_TICKS)
        ) u_ch (
            .clk       (clk),
            .i_rst     (i_rst),
            .i_tick    (tick),
            .i_event   (i_event[k]),
            .i_clear   (i_clear[k]),
            .i_mode    (i_mode[2*k +: 2]),
            .i_led_en  (led_en),
            .o_active  (o_active[k]),
            .o_led     (o_led[k]),
            .o_overrun (o_overrun[k])
        );
    end

endmodule

// File: tb/tb_led_activity_stretcher.sv
// Self-checking bench for led_activity_stretcher: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model
// (tick counting since load, total blink ticks since activation).
`timescale 1ns/1ps
module tb_led_activity_stretcher;

    localparam int NB_CH       = 4;
    localparam int TICK_DIV    = 10;
    localparam int HOLD_TICKS  = 5;
    localparam int BLINK_TICKS = 2;
    localparam int NB_PWM      = 4;

    logic                clk = 1'b0;
    logic                i_rst;
    logic [NB_CH-1:0]    i_event;
    logic [2*NB_CH-1:0]  i_mode;
    logic [NB_CH-1:0]    i_clear;
`ifdef LED_PWM_EN
    logic [NB_PWM-1:0]   i_duty;
`endif
    logic [NB_CH-1:0]    o_active;
    logic [NB_CH-1:0]    o_led;
    logic [NB_CH-1:0]    o_overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_k;                 // cycles since reset released
    int m_tk;                // ticks since reset released
    int m_st   [NB_CH];      // 0 idle, 1 hold, 2 latch
    int m_load [NB_CH];      // tick count at last (re)load
    int m_bt   [NB_CH];      // blink ticks since activation
    bit m_ovr  [NB_CH];
    int m_pwm;
    logic [NB_CH-1:0] exp_act, exp_led, exp_ovr;

    always #5 clk = ~clk;

    led_activity_stretcher #(
        .NB_CH       (NB_CH),
        .TICK_DIV    (TICK_DIV),
        .HOLD_TICKS  (HOLD_TICKS),
        .BLINK_TICKS (BLINK_TICKS),
        .NB_PWM      (NB_PWM)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_event   (i_event),
        .i_mode    (i_mode),
        .i_clear   (i_clear),
`ifdef LED_PWM_EN
        .i_duty    (i_duty),
`endif
        .o_active  (o_active),
        .o_led     (o_led),
        .o_overrun (o_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit tick;
        bit gate;
        int md;
        gate = 1'b1;
        if (i_rst) begin
            m_k = 0;
            m_tk = 0;
            m_pwm = 0;
            for (int c = 0; c < NB_CH; c++) begin
                m_st[c] = 0; m_ovr[c] = 0; m_bt[c] = 0; m_load[c] = 0;
            end
        end else begin
            tick = ((m_k % TICK_DIV) == TICK_DIV - 1);
            m_k++;
            if (tick) m_tk++;
`ifdef LED_PWM_EN
            gate = (m_pwm < int'(i_duty));
            m_pwm = (m_pwm + 1) % (1 << NB_PWM);
`endif
            for (int c = 0; c < NB_CH; c++) begin
                md = int'(i_mode[2*c +: 2]);
                if (i_clear[c]) begin
                    m_st[c] = 0; m_ovr[c] = 0; m_bt[c] = 0;
                end else if (m_st[c] == 0) begin
                    if (i_event[c]) begin
                        m_st[c] = (md == 3) ? 2 : 1;
                        m_load[c] = m_tk;
                        m_bt[c] = 0;
                    end
                end else if (m_st[c] == 1) begin
                    if (tick && md == 2) m_bt[c]++;
                    if (i_event[c] && md != 0) begin
                        m_load[c] = m_tk;
                    end else begin
                        if (i_event[c]) m_ovr[c] = 1;
                        if (tick && (m_tk - m_load[c] == HOLD_TICKS)) m_st[c] = 0;
                    end
                end
            end
        end
        for (int c = 0; c < NB_CH; c++) begin
            md = int'(i_mode[2*c +: 2]);
            exp_act[c] = (m_st[c] != 0);
            exp_led[c] = exp_act[c] && (md != 2 || ((m_bt[c] / BLINK_TICKS) % 2 == 0)) && gate;
            exp_ovr[c] = m_ovr[c];
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("active", 32'(o_active), 32'(exp_act));
        check("led", 32'(o_led), 32'(exp_led));
        check("overrun", 32'(o_overrun), 32'(exp_ovr));
    endtask

    task automatic idle_inputs();
        i_rst = 1'b0; i_event = '0; i_clear = '0; i_mode = '0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        i_rst = 1'b1;
        repeat (cycles) step();
        i_rst = 1'b0;
    endtask

    // Idle until the next cycle is a tick cycle (directed "cycle 0").
    task automatic align();
        for (int i = 0; i < TICK_DIV && (m_k % TICK_DIV) != TICK_DIV - 1; i++) step();
    endtask

    // Directed scenario on channel 0 with literal expectations per cycle.
    task automatic run_scn(input int id, input int len);
        int c;
        bit ea, el, eo;
        do_reset(1);
        align();
        for (int n = 0; n < len; n++) begin
            idle_inputs();
            c = n + 1;
            ea = 0; el = 0; eo = 0;
            case (id)
                1: begin
                    i_mode[1:0] = 2'd0;
                    i_event[0]  = (n == 0 || n == 20);
                    i_clear[0]  = (n == 60);
                    ea = (c <= 50); el = ea; eo = (c >= 21 && c <= 60);
                end
                2: begin
                    i_mode[1:0] = 2'd1;
                    i_event[0]  = (n == 0 || n == 20);
                    ea = (c <= 70); el = ea;
                end
                3: begin
                    i_mode[1:0] = 2'd2;
                    i_event[0]  = (n == 0);
                    ea = (c <= 50); el = (c <= 20) || (c >= 41 && c <= 50);
                end
                4: begin
                    i_mode[1:0] = 2'd3;
                    i_event[0]  = (n == 0 || n == 200);
                    i_clear[0]  = (n == 200);
                    ea = (c <= 200); el = ea;
                end
                default: begin
                    i_mode[1:0] = 2'd1;
                    i_event[0]  = (n == 0 || n == 30);
                    i_rst       = (n == 25 || n == 26);
                    ea = (c <= 25) || (c >= 31 && c <= 76); el = ea;
                end
            endcase
`ifdef LED_PWM_EN
            i_duty = '1;
`endif
            step();
            check($sformatf("s%0d_active@%0d", id, c), 32'(o_active[0]), 32'(ea));
`ifndef LED_PWM_EN
            check($sformatf("s%0d_led@%0d", id, c), 32'(o_led[0]), 32'(el));
`endif
            check($sformatf("s%0d_overrun@%0d", id, c), 32'(o_overrun[0]), 32'(eo));
        end
    endtask

    initial begin
        for (int c = 0; c < NB_CH; c++) begin
            m_st[c] = 0; m_load[c] = 0; m_bt[c] = 0; m_ovr[c] = 0;
        end
        m_k = 0; m_tk = 0; m_pwm = 0;
`ifdef LED_PWM_EN
        i_duty = '1;
`endif
        idle_inputs();
        @(negedge clk);
        do_reset(2);
        check("reset_active", 32'(o_active), 32'd0);
        check("reset_led", 32'(o_led), 32'd0);
        check("reset_overrun", 32'(o_overrun), 32'd0);

        run_scn(1, 70);
        run_scn(2, 80);
        run_scn(3, 60);
        run_scn(4, 210);
        run_scn(5, 90);

`ifdef LED_PWM_EN
        begin
            int cnt;
            do_reset(1);
            align();
            i_duty = 4'd4;
            i_mode[1:0] = 2'd3;
            i_event[0] = 1'b1;
            step();
            i_event[0] = 1'b0;
            cnt = 0;
            for (int i = 0; i < 16; i++) begin step(); cnt += int'(o_led[0]); end
            check("pwm_duty4_on_cycles", 32'(cnt), 32'd4);
            i_duty = '0;
            cnt = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                cnt += int'(o_led[0]);
                check("pwm_duty0_active", 32'(o_active[0]), 32'd1);
            end
            check("pwm_duty0_on_cycles", 32'(cnt), 32'd0);
        end
`endif

        // Randomized traffic against the model.
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) i_mode = (2*NB_CH)'($urandom);
            for (int c = 0; c < NB_CH; c++) begin
                i_event[c] = ($urandom_range(0, 11) == 0);
                i_clear[c] = ($urandom_range(0, 99) == 0);
            end
            if (!i_rst) i_rst = ($urandom_range(0, 799) == 0);
            else        i_rst = ($urandom_range(0, 1) == 0);
`ifdef LED_PWM_EN
            if (n % 64 == 0) i_duty = NB_PWM'($urandom);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
